// File: rtl/proximity_pkg.sv
// Shared types and default thresholds for the ultrasonic proximity filter.
package proximity_pkg;

  localparam int DIST_W = 20;
  localparam int SUM_W  = 22;

  localparam int DEF_NEAR_CM = 10;
  localparam int DEF_FAR_CM  = 15;
  localparam int DEF_MAX_CM  = 400;
  localparam int DEF_CONFIRM = 3;

  typedef enum logic [1:0] {
    ST_FAR       = 2'd0,
    ST_NEAR_PEND = 2'd1,
    ST_NEAR      = 2'd2,
    ST_FAR_PEND  = 2'd3
  } prox_state_t;

endpackage

// File: rtl/avg4_window.sv
// Four-entry moving-average window; sum updates one edge after the sample,
// the floored average one edge later.
module avg4_window
  import proximity_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] sample,
  input  logic              sample_valid,
  output logic [DIST_W-1:0] avg,
  output logic              avg_valid
);

  logic [DIST_W-1:0] win0, win1, win2, win3;
  logic [SUM_W-1:0]  sum;
  logic [2:0]        fill;
  logic              pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win0 <= '0;
      win1 <= '0;
      win2 <= '0;
      win3 <= '0;
      sum  <= '0;
      fill <= '0;
      pend <= 1'b0;
    end else begin
      pend <= sample_valid;
      if (sample_valid) begin
        win0 <= sample;
        win1 <= win0;
        win2 <= win1;
        win3 <= win2;
        // win3 is the oldest entry and drops out of the running sum
        sum  <= sum + SUM_W'(sample) - SUM_W'(win3);
        if (fill != 3'd4) fill <= fill + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= pend && (fill == 3'd4);
      if (pend) avg <= sum[SUM_W-1:2];
    end
  end

endmodule

// File: rtl/proximity_filter.sv
// Ultrasonic proximity filter: range check, 4-sample average, then a
// hysteresis FSM that needs CONFIRM consecutive qualifying averages to flip.
module proximity_filter
  import proximity_pkg::*;
#(
  parameter int NEAR_CM = DEF_NEAR_CM,
  parameter int FAR_CM  = DEF_FAR_CM,
  parameter int MAX_CM  = DEF_MAX_CM,
  parameter int CONFIRM = DEF_CONFIRM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] distance,
  input  logic              sample_tick,
  output logic [DIST_W-1:0] avg_distance,
  output logic              avg_valid,
  output logic              rejected,
  output logic              obstacle,
  output logic              obstacle_rise
);

  localparam logic [DIST_W-1:0] NEAR_V    = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] FAR_V     = DIST_W'(FAR_CM);
  localparam logic [DIST_W-1:0] MAX_V     = DIST_W'(MAX_CM);
  localparam logic [3:0]        CONFIRM_V = 4'(CONFIRM);

  logic        accept;
  prox_state_t state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic        next_obstacle;
  logic        near_hit, far_hit;

  assign accept = sample_tick && (distance != '0) && (distance <= MAX_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rejected <= 1'b0;
    else     rejected <= sample_tick && !accept;
  end

  avg4_window u_window (
    .clk          (clk),
    .rst          (rst),
    .sample       (distance),
    .sample_valid (accept),
    .avg          (avg_distance),
    .avg_valid    (avg_valid)
  );

  // Values equal to a threshold sit in the hysteresis band and never qualify.
  assign near_hit = avg_distance < NEAR_V;
  assign far_hit  = avg_distance > FAR_V;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_FAR;
      cnt           <= '0;
      obstacle      <= 1'b0;
      obstacle_rise <= 1'b0;
    end else begin
      state         <= next_state;
      cnt           <= next_cnt;
      obstacle      <= next_obstacle;
      obstacle_rise <= next_obstacle && !obstacle;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (avg_valid) begin
      unique case (state)
        ST_FAR: begin
          if (near_hit) begin
            next_state = ST_NEAR_PEND;
            next_cnt   = 4'd1;
          end
        end
        ST_NEAR_PEND: begin
          if (near_hit) begin
            next_cnt = cnt + 4'd1;
            if (cnt + 4'd1 == CONFIRM_V) next_state = ST_NEAR;
          end else begin
            next_state = ST_FAR;
            next_cnt   = '0;
          end
        end
        ST_NEAR: begin
          if (far_hit) begin
            next_state = ST_FAR_PEND;
            next_cnt   = 4'd1;
          end
        end
        ST_FAR_PEND: begin
          if (far_hit) begin
            next_cnt = cnt + 4'd1;
            if (cnt + 4'd1 == CONFIRM_V) next_state = ST_FAR;
          end else begin
            next_state = ST_NEAR;
            next_cnt   = '0;
          end
        end
        default: begin
          next_state = ST_FAR;
          next_cnt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    next_obstacle = (next_state == ST_NEAR) || (next_state == ST_FAR_PEND);
  end

endmodule
